bp_sched_8051: RTL
==================

# bp_sched_8051

Sequencing controller for the 8051 core's single-ported 2-bit branch history table (BHT). It shares the table between fetch-side prediction lookups and execute-side branch resolutions, serialising reads and read-modify-write updates. It tracks up to DEPTH in-flight predictions in order, detects mispredicts at resolution, and pulses a pipeline flush.

## Interface
- DEPTH, 4: in-flight prediction FIFO depth (power of 2, ≥2)
- IDX_W, 8: BHT index width; index = pc[IDX_W+1:2]

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- pred_req  in  1  fetch requests a prediction; held until pred_valid
- pred_pc  in  16  branch PC; sampled only in the grant cycle
- pred_valid  out  1  one-cycle pulse, prediction result ready
- pred_taken  out  1  predicted direction; valid with pred_valid
- res_valid  in  1  execute presents the oldest branch outcome
- res_taken  in  1  actual direction
- res_ready  out  1  resolve handshake accepted this cycle (combinational)
- flush  out  1  one-cycle mispredict pulse
- bht_rd_en  out  1  table read strobe (combinational)
- bht_idx  out  IDX_W  read/write index (combinational)
- bht_rd_data  in  2  counter; valid the cycle after bht_rd_en (synchronous read)
- bht_wr_en  out  1  table write strobe
- bht_wr_data  out  2  new counter value
- inflight  out  log2(DEPTH)+1  current FIFO occupancy
- stat_branches  out  16  resolved-branch count, wraps
- stat_mispred  out  16  mispredict count, wraps

## Operation
- FSM states: IDLE, PRED_WAIT, UPD_CALC, UPD_WR. Table access is allowed only in IDLE (read) and UPD_WR (write), so the table sees at most one access per cycle.
- IDLE arbitration: resolve has priority over lookup.
  - Resolve grant: res_ready = res_valid & (inflight≠0). On grant, bht_rd_en=1 and bht_idx=head.idx. Capture res_taken and mispredict = (head.taken ≠ res_taken). Pop the head. Go to UPD_CALC.
  - Lookup grant: pred_req & no resolve grant & (inflight<DEPTH). On grant, bht_rd_en=1 and bht_idx=pred_pc[IDX_W+1:2]; latch the idx. Go to PRED_WAIT.
  - Otherwise stay in IDLE with no strobes.
- PRED_WAIT: pred_taken <= bht_rd_data[1], pred_valid <= 1. Push {idx, bht_rd_data[1]} into the FIFO. Go to IDLE.
- UPD_CALC: compute new = rd_data+1 if taken and ≠11; rd_data−1 if not taken and ≠00; else unchanged (saturate at 11/00). Register it. Go to UPD_WR.
- UPD_WR: bht_wr_en=1, bht_idx=stored idx, bht_wr_data=new. Go to IDLE.
- Mispredict: flush pulses the cycle after the resolve grant. In the same edge, all remaining FIFO entries are discarded (inflight=0) and stat_mispred is incremented. The table update still completes.
- stat_branches increments the cycle after every resolve grant.
- res_valid with an empty FIFO is never acknowledged; it has no effect.

## Timing
- Reset (asynchronous): state=IDLE, FIFO empty, inflight=0. pred_valid, pred_taken, flush, bht_wr_en, bht_wr_data and both stats are all 0.
- Lookup: grant in cycle T (bht_rd_en high in T); pred_valid/pred_taken high in T+2; next grant possible in T+2.
- Resolve: grant in T; flush and stat updates in T+1; bht_wr_en in T+2; next grant possible in T+3.
- Read-after-write: a lookup granted in T+3 reads the value written in T+2.
- Simultaneous res_valid and pred_req in IDLE: resolve wins; pred_req waits with no loss.
- FIFO full: lookups stall (no bht_rd_en) until a resolve pops an entry. The pointers wrap modulo DEPTH.
- Reset asserted mid-update: the write is abandoned and no bht_wr_en is issued after reset.

## Test plan
- Cold lookup: reset, table holds 01 at idx 0x10, pred_pc=0x0040 → bht_rd_en with idx=0x10 in T; pred_valid=1, pred_taken=0 in T+2; inflight=1.
- Correct resolve: after the above, res_valid=1, res_taken=0 → res_ready in T; flush=0 in T+1; bht_wr_en=1, bht_wr_data=00 in T+2; stat_branches=1.
- Saturation: counter at 11 resolved taken → bht_wr_data=11; counter at 00 resolved not-taken → bht_wr_data=00.
- Mispredict flush: three lookups predicted not-taken (inflight=3), resolve first as taken → flush=1 one cycle, inflight=0, stat_mispred=1; bht_wr_data=10 from 01.
- Contention and full: DEPTH lookups fill the FIFO; pred_req stays high with no bht_rd_en. Simultaneous res_valid is granted first; a lookup is granted in IDLE after UPD_WR.
- Async reset mid-UPD_CALC → outputs 0 immediately, no bht_wr_en afterwards, inflight=0, stats=0.

Source files
------------

// File: rtl/bp_sched_8051.sv
// Arbitrates the single-ported 2-bit branch history table between fetch lookups and execute resolutions.
// Tracks in-flight predictions in order and pulses flush on a mispredict.
module bp_sched_8051 #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pred_req,
  input  logic [15:0]              pred_pc,
  output logic                     pred_valid,
  output logic                     pred_taken,
  input  logic                     res_valid,
  input  logic                     res_taken,
  output logic                     res_ready,
  output logic                     flush,
  output logic                     bht_rd_en,
  output logic [IDX_W-1:0]         bht_idx,
  input  logic [1:0]               bht_rd_data,
  output logic                     bht_wr_en,
  output logic [1:0]               bht_wr_data,
  output logic [$clog2(DEPTH):0]   inflight,
  output logic [15:0]              stat_branches,
  output logic [15:0]              stat_mispred
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, PRED_WAIT, UPD_CALC, UPD_WR} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   fifo_idx_q [DEPTH];
  logic               fifo_tkn_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   pred_idx_q, upd_idx_q;
  logic               res_tkn_q;
  logic [1:0]         upd_cnt_q, upd_cnt_d;
  logic               pred_valid_q, pred_taken_q, flush_q;
  logic [15:0]        stat_br_q, stat_mis_q;

  logic               res_grant, pred_grant, mispred;
  logic [IDX_W-1:0]   head_idx;

  assign head_idx   = fifo_idx_q[rd_ptr_q];
  assign mispred    = fifo_tkn_q[rd_ptr_q] != res_taken;
  assign res_grant  = (state_q == IDLE) && res_valid && (cnt_q != '0);
  assign pred_grant = (state_q == IDLE) && pred_req && !res_grant && (cnt_q < FULL);

  always_comb begin
    state_d   = state_q;
    bht_rd_en = 1'b0;
    bht_idx   = '0;
    case (state_q)
      IDLE: begin
        if (res_grant) begin
          bht_rd_en = 1'b1;
          bht_idx   = head_idx;
          state_d   = UPD_CALC;
        end else if (pred_grant) begin
          bht_rd_en = 1'b1;
          bht_idx   = pred_pc[IDX_W+1:2];
          state_d   = PRED_WAIT;
        end
      end
      PRED_WAIT: state_d = IDLE;
      UPD_CALC:  state_d = UPD_WR;
      UPD_WR: begin
        bht_idx = upd_idx_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Saturating 2-bit counter step toward the resolved direction.
  always_comb begin
    upd_cnt_d = bht_rd_data;
    if (res_tkn_q && bht_rd_data != 2'b11)
      upd_cnt_d = bht_rd_data + 2'd1;
    else if (!res_tkn_q && bht_rd_data != 2'b00)
      upd_cnt_d = bht_rd_data - 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      pred_idx_q   <= '0;
      upd_idx_q    <= '0;
      res_tkn_q    <= 1'b0;
      upd_cnt_q    <= 2'b00;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      flush_q      <= 1'b0;
      stat_br_q    <= '0;
      stat_mis_q   <= '0;
    end else begin
      state_q      <= state_d;
      pred_valid_q <= 1'b0;
      flush_q      <= 1'b0;
      if (res_grant) begin
        upd_idx_q <= head_idx;
        res_tkn_q <= res_taken;
        stat_br_q <= stat_br_q + 16'd1;
        // A mispredict discards every younger prediction along with the head.
        if (mispred) begin
          flush_q    <= 1'b1;
          stat_mis_q <= stat_mis_q + 16'd1;
          cnt_q      <= '0;
          rd_ptr_q   <= wr_ptr_q;
        end else begin
          cnt_q    <= cnt_q - 1'b1;
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
      end
      if (pred_grant)
        pred_idx_q <= pred_pc[IDX_W+1:2];
      if (state_q == PRED_WAIT) begin
        pred_valid_q <= 1'b1;
        pred_taken_q <= bht_rd_data[1];
        wr_ptr_q     <= wr_ptr_q + 1'b1;
        cnt_q        <= cnt_q + 1'b1;
      end
      if (state_q == UPD_CALC)
        upd_cnt_q <= upd_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == PRED_WAIT) begin
      fifo_idx_q[wr_ptr_q] <= pred_idx_q;
      fifo_tkn_q[wr_ptr_q] <= bht_rd_data[1];
    end
  end

  assign res_ready     = res_grant;
  assign pred_valid    = pred_valid_q;
  assign pred_taken    = pred_taken_q;
  assign flush         = flush_q;
  assign bht_wr_en     = (state_q == UPD_WR);
  assign bht_wr_data   = upd_cnt_q;
  assign inflight      = cnt_q;
  assign stat_branches = stat_br_q;
  assign stat_mispred  = stat_mis_q;

endmodule
